// File: rtl/btb_nway_assoc_pkg.sv
// Shared BPU definitions for the branch target buffer.
// Holds the branch-type encoding used by predecode, the BTB and the
// downstream predictors, plus the width of that encoding.
package btb_nway_assoc_pkg;

    localparam int unsigned BTB_TYPE_W = 3;

    typedef enum logic [BTB_TYPE_W-1:0] {
        BTB_FORMAL = 3'd0,
        BTB_BRANCH = 3'd1,
        BTB_CALL   = 3'd2,
        BTB_RET    = 3'd3,
        BTB_JUMP   = 3'd4
    } btb_type_e;

endpackage

// File: rtl/btb_victim_sel.sv
// Victim way selection for one BTB set (purely combinational).
// The lowest-index invalid way is preferred. When every way is valid, the
// oldest way is chosen, with ties going to the lowest index.
// Ports:
//   Valid  [WAYS]        per-way valid bits of the set
//   Age    [WAYS*AGE_W]  per-way age counters, way 0 in the LSBs
//   Victim [log2(WAYS)]  selected way index
module btb_victim_sel #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned AGE_W = 4
) (
    input  logic [WAYS-1:0]         Valid,
    input  logic [WAYS*AGE_W-1:0]   Age,
    output logic [$clog2(WAYS)-1:0] Victim
);

    localparam int unsigned WAYW = $clog2(WAYS);

    logic             foundFree;
    logic [WAYW-1:0]  freeWay;
    logic [WAYW-1:0]  oldWay;
    logic [AGE_W-1:0] oldAge;

    always_comb begin
        foundFree = 1'b0;
        freeWay   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!foundFree && !Valid[w]) begin
                foundFree = 1'b1;
                freeWay   = WAYW'(w);
            end
        end
    end

    // Strict '>' keeps the lowest index on equal ages.
    always_comb begin
        oldWay = '0;
        oldAge = Age[0 +: AGE_W];
        for (int unsigned w = 1; w < WAYS; w++) begin
            if (Age[w*AGE_W +: AGE_W] > oldAge) begin
                oldAge = Age[w*AGE_W +: AGE_W];
                oldWay = WAYW'(w);
            end
        end
    end

    assign Victim = foundFree ? freeWay : oldWay;

endmodule

// File: rtl/btb_nway_assoc.sv
// N-way set-associative branch target buffer.
// A lookup reads the indexed set combinationally and registers the next-PC
// prediction (1-cycle latency). A separate update port allocates entries or
// rewrites individual fields. Per-way age counters drive victim choice.
// Ports:
//   Clk, Rest        clock, synchronous active-high reset
//   Stall            hold output regs, block all table/age writes
//   Flush            clear output regs (tables untouched)
//   LkValid, LkPc    lookup request and PC
//   Up*              update request: way select, PC, per-field enables/data
//   Pred*            registered prediction: valid, hit, way, next PC,
//                    offset, taken, type
module btb_nway_assoc
    import btb_nway_assoc_pkg::*;
#(
    parameter int unsigned SETS        = 256,
    parameter int unsigned WAYS        = 4,
    parameter int unsigned AW          = 32,
    parameter int unsigned FETCH_BYTES = 32,
    parameter int unsigned HIST        = 4,
    parameter int unsigned AGE_W       = 4
) (
    input  logic                          Clk,
    input  logic                          Rest,
    input  logic                          Stall,
    input  logic                          Flush,
    input  logic                          LkValid,
    input  logic [AW-1:0]                 LkPc,
    input  logic                          UpValid,
    input  logic                          UpWayValid,
    input  logic [$clog2(WAYS)-1:0]       UpWay,
    input  logic [AW-1:0]                 UpPc,
    input  logic                          UpHistEn,
    input  logic [HIST-1:0]               UpHist,
    input  logic                          UpTypeEn,
    input  logic [BTB_TYPE_W-1:0]         UpType,
    input  logic                          UpTgtEn,
    input  logic [AW-1:0]                 UpTgt,
    output logic                          PredValid,
    output logic                          PredHit,
    output logic [$clog2(WAYS)-1:0]       PredWay,
    output logic [AW-1:0]                 PredPc,
    output logic [$clog2(FETCH_BYTES)-1:0] PredOffset,
    output logic                          PredTaken,
    output logic [BTB_TYPE_W-1:0]         PredType
);

    localparam int unsigned OFFW = $clog2(FETCH_BYTES);
    localparam int unsigned SETW = $clog2(SETS);
    localparam int unsigned WAYW = $clog2(WAYS);
    localparam int unsigned TAGW = AW - SETW - OFFW;

    logic [SETW-1:0] lkSet, upSet;
    logic [TAGW-1:0] lkTag, upTag;
    logic            unusedUpOffset;

    assign lkSet          = LkPc[OFFW +: SETW];
    assign lkTag          = LkPc[AW-1 -: TAGW];
    assign upSet          = UpPc[OFFW +: SETW];
    assign upTag          = UpPc[AW-1 -: TAGW];
    assign unusedUpOffset = ^UpPc[OFFW-1:0];

    // Per-way views of the lookup set and the update set
    logic [WAYS-1:0]       lkWayValid;
    logic [TAGW-1:0]       lkWayTag  [WAYS];
    logic [HIST-1:0]       lkWayHist [WAYS];
    btb_type_e             lkWayType [WAYS];
    logic [AW-1:0]         lkWayTgt  [WAYS];
    logic [WAYS-1:0]       upRowValid;
    logic [WAYS*AGE_W-1:0] upRowAge;

    logic            lkHit, lkTaken, lkFire, upFire;
    logic [WAYW-1:0] hitWay, victimWay, upWayIdx;
    logic [HIST-1:0] hitHist;
    btb_type_e       hitType;
    logic [AW-1:0]   hitTgt, fallThru;
    int unsigned     popCnt;

    // Lowest matching way wins on multiple hits.
    always_comb begin
        lkHit  = 1'b0;
        hitWay = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!lkHit && lkWayValid[w] && (lkWayTag[w] == lkTag)) begin
                lkHit  = 1'b1;
                hitWay = WAYW'(w);
            end
        end
    end

    assign hitHist = lkWayHist[hitWay];
    assign hitType = lkWayType[hitWay];
    assign hitTgt  = lkWayTgt[hitWay];

    always_comb begin
        popCnt = 0;
        for (int unsigned i = 0; i < HIST; i++) begin
            if (hitHist[i]) popCnt++;
        end
    end

    assign lkTaken  = lkHit && ((hitType == BTB_BRANCH) ? (popCnt > HIST / 2)
                                                        : (hitType != BTB_FORMAL));
    assign fallThru = {LkPc[AW-1:OFFW], {OFFW{1'b0}}} + AW'(FETCH_BYTES);

    assign lkFire   = LkValid && lkHit && !Stall;
    assign upFire   = UpValid && !Stall;
    assign upWayIdx = UpWayValid ? UpWay : victimWay;

    btb_victim_sel #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) uVictimSel (
        .Valid  (upRowValid),
        .Age    (upRowAge),
        .Victim (victimWay)
    );

    for (genvar w = 0; w < WAYS; w++) begin : gWay
        logic             validQ [SETS];
        logic [TAGW-1:0]  tagQ   [SETS];
        logic [HIST-1:0]  histQ  [SETS];
        btb_type_e        typeQ  [SETS];
        logic [AW-1:0]    tgtQ   [SETS];
        logic [AGE_W-1:0] ageQ   [SETS];

        assign lkWayValid[w]                = validQ[lkSet];
        assign lkWayTag[w]                  = tagQ[lkSet];
        assign lkWayHist[w]                 = histQ[lkSet];
        assign lkWayType[w]                 = typeQ[lkSet];
        assign lkWayTgt[w]                  = tgtQ[lkSet];
        assign upRowValid[w]                = validQ[upSet];
        assign upRowAge[w*AGE_W +: AGE_W]   = ageQ[upSet];

        // Lookup effects are issued first; the update-port writes follow in
        // the same block so they override history and age on a collision.
        always_ff @(posedge Clk) begin
            if (Rest) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    validQ[s] <= 1'b0;
                    tagQ[s]   <= '0;
                    histQ[s]  <= '0;
                    typeQ[s]  <= BTB_FORMAL;
                    tgtQ[s]   <= '0;
                    ageQ[s]   <= '0;
                end
            end else begin
                if (lkFire) begin
                    if (hitWay == WAYW'(w)) begin
                        histQ[lkSet] <= {histQ[lkSet][HIST-2:0], lkTaken};
                        ageQ[lkSet]  <= '0;
                    end else if (validQ[lkSet] && (ageQ[lkSet] != '1)) begin
                        ageQ[lkSet]  <= ageQ[lkSet] + 1'b1;
                    end
                end
                if (upFire && (upWayIdx == WAYW'(w))) begin
                    validQ[upSet] <= 1'b1;
                    tagQ[upSet]   <= upTag;
                    ageQ[upSet]   <= '0;
                    if (UpHistEn)           histQ[upSet] <= UpHist;
                    else if (!validQ[upSet]) histQ[upSet] <= '0;
                    if (UpTypeEn)           typeQ[upSet] <= btb_type_e'(UpType);
                    else if (!validQ[upSet]) typeQ[upSet] <= BTB_FORMAL;
                    if (UpTgtEn)            tgtQ[upSet]  <= UpTgt;
                    else if (!validQ[upSet]) tgtQ[upSet]  <= '0;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rest || (!Stall && (Flush || !LkValid))) begin
            PredValid  <= 1'b0;
            PredHit    <= 1'b0;
            PredWay    <= '0;
            PredPc     <= '0;
            PredOffset <= '0;
            PredTaken  <= 1'b0;
            PredType   <= '0;
        end else if (!Stall) begin
            PredValid  <= 1'b1;
            PredHit    <= lkHit;
            PredWay    <= hitWay;
            PredPc     <= lkTaken ? hitTgt : fallThru;
            PredOffset <= LkPc[OFFW-1:0];
            PredTaken  <= lkTaken;
            PredType   <= lkHit ? hitType : BTB_FORMAL;
        end
    end

endmodule
